// File: rtl/regwr_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regwr_pkg;

  localparam int NREQ_DEF  = 3;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = 5;
  localparam int DW_DEF    = 32;

  // Register 0, optionally write-protected.
  localparam int R0_ADDR = 0;

  // Sequencer states: normal arbitration or register clear sweep.
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Index width that never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester after ptr (wrapping) wins.
// Latency: combinational, 0 cycles.
// Backpressure: none; the caller masks the result when it cannot accept.
module rr_arbiter
  import regwr_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int PW   = idx_width(NREQ_DEF)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   win,
  output logic            found
);

  // Scan ptr+1, ptr+2, ... ptr (mod NREQ); the last-served requester goes last.
  always_comb begin
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        win   = PW'((int'(ptr) + k) % NREQ);
        gnt[(int'(ptr) + k) % NREQ] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between NREQ writers and runs clear sweeps.
// Latency: gnt combinational with req; reg_ena/reg_d one cycle after gnt.
// Backpressure: requests held until gnt; none granted during a sweep or on clear_go.
// Build option: define REGWR_R0_PROTECT_EN to make r0 read-only (writes granted, dropped).
module regfile_wr_arbiter
  import regwr_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  input  logic              clear_go,
  output logic              clear_busy,
  output logic [NREGS-1:0]  reg_ena,
  output logic [NREGS-1:0]  reg_clr,
  output logic [DW-1:0]     reg_d
);

  localparam int PW = idx_width(NREQ);
  localparam int CW = idx_width(NREGS);

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [CW-1:0]   sweep_cnt;

  logic [NREQ-1:0] arb_gnt;
  logic [PW-1:0]   win;
  logic            found;
  logic            arb_en;
  logic            fire;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;
  logic            write_ok;
  logic [NREGS-1:0] ena_vec;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .gnt   (arb_gnt),
    .win   (win),
    .found (found)
  );

  // Grants only in IDLE, out of reset, and when no clear is being started.
  always_comb begin
    arb_en   = clrn && (state == IDLE) && !clear_go;
    fire     = arb_en && found;
    gnt      = arb_en ? arb_gnt : '0;
    win_addr = req_addr[win*AW +: AW];
    win_data = req_data[win*DW +: DW];
`ifdef REGWR_R0_PROTECT_EN
    write_ok = (int'(win_addr) < NREGS) && (win_addr != AW'(R0_ADDR));
`else
    write_ok = (int'(win_addr) < NREGS);
`endif
    ena_vec  = write_ok ? (NREGS'(1) << win_addr) : '0;
  end

  assign clear_busy = (state == CLEAR);

  // FSM, round-robin pointer, sweep counter and registered row drives.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= IDLE;
      rr_ptr    <= PW'(NREQ - 1);
      sweep_cnt <= '0;
      reg_ena   <= '0;
      reg_clr   <= '0;
      reg_d     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_go) begin
            // First swept row is presented together with clear_busy.
            state     <= CLEAR;
            sweep_cnt <= '0;
            reg_clr   <= NREGS'(1);
            reg_ena   <= '0;
          end else if (fire) begin
            rr_ptr  <= win;
            reg_ena <= ena_vec;
            reg_d   <= win_data;
          end else begin
            reg_ena <= '0;
          end
        end
        CLEAR: begin
          reg_ena <= '0;
          if (sweep_cnt == CW'(NREGS - 1)) begin
            state     <= IDLE;
            sweep_cnt <= '0;
            reg_clr   <= '0;
          end else begin
            sweep_cnt <= sweep_cnt + 1'b1;
            reg_clr   <= reg_clr << 1;
          end
        end
        default: begin
          state   <= IDLE;
          reg_ena <= '0;
          reg_clr <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios plus random traffic
// compared each cycle against a queue-based round-robin model.
// Honours REGWR_R0_PROTECT_EN the same way as the design.
module tb_regfile_wr_arbiter;

  localparam int NREQ  = 3;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic                 clk = 1'b0;
  logic                 clrn;
  logic [NREQ-1:0]      req;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      gnt;
  logic                 clear_go;
  logic                 clear_busy;
  logic [NREGS-1:0]     reg_ena;
  logic [NREGS-1:0]     reg_clr;
  logic [DW-1:0]        reg_d;

  regfile_wr_arbiter #(
    .NREQ (NREQ), .NREGS (NREGS), .AW (AW), .DW (DW)
  ) dut (
    .clk        (clk),
    .clrn       (clrn),
    .req        (req),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .gnt        (gnt),
    .clear_go   (clear_go),
    .clear_busy (clear_busy),
    .reg_ena    (reg_ena),
    .reg_clr    (reg_clr),
    .reg_d      (reg_d)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Requester side: pending write per requester.
  bit             p_vld  [NREQ];
  logic [AW-1:0]  p_addr [NREQ];
  logic [DW-1:0]  p_data [NREQ];

  // Model: priority list (head = highest priority), sweep progress, expected outputs.
  int             m_order [NREQ];
  bit             m_busy;
  int             m_idx;
  logic [NREGS-1:0] m_ena, m_clr;
  logic [DW-1:0]  m_d;
  logic [NREQ-1:0] last_gnt;

  // DUT values observed in the most recent checked cycle.
  logic [NREQ-1:0]  obs_gnt;
  logic [NREGS-1:0] obs_ena, obs_clr;
  logic [DW-1:0]    obs_d;
  logic             obs_busy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req[i]                = p_vld[i];
      req_addr[i*AW +: AW]  = p_addr[i];
      req_data[i*DW +: DW]  = p_data[i];
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) m_order[i] = i;
    m_busy = 0; m_idx = 0; m_ena = '0; m_clr = '0; m_d = '0;
  endtask

  function automatic bit writable(input logic [AW-1:0] a);
`ifdef REGWR_R0_PROTECT_EN
    return (int'(a) < NREGS) && (a != 0);
`else
    return int'(a) < NREGS;
`endif
  endfunction

  // One clock: compare at negedge, advance model, then re-drive after posedge.
  task automatic tick();
    int w;
    logic [NREQ-1:0] eg;
    @(negedge clk);
    w = -1;
    if (!m_busy && !clear_go)
      for (int j = NREQ - 1; j >= 0; j--) if (req[m_order[j]]) w = m_order[j];
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    obs_gnt = gnt; obs_ena = reg_ena; obs_clr = reg_clr; obs_d = reg_d; obs_busy = clear_busy;
    check("gnt",        64'(gnt),        64'(eg));
    check("reg_ena",    64'(reg_ena),    64'(m_ena));
    check("reg_clr",    64'(reg_clr),    64'(m_clr));
    check("reg_d",      64'(reg_d),      64'(m_d));
    check("clear_busy", 64'(clear_busy), 64'(m_busy));
    check("ena_clr_excl", 64'((|reg_ena) && (|reg_clr)), 64'(0));
    if (m_busy) begin
      m_ena = '0;
      if (m_idx == NREGS - 1) begin
        m_busy = 0; m_idx = 0; m_clr = '0;
      end else begin
        m_idx++; m_clr = '0; m_clr[m_idx] = 1'b1;
      end
    end else if (clear_go) begin
      m_busy = 1; m_idx = 0; m_clr = '0; m_clr[0] = 1'b1; m_ena = '0;
    end else if (w >= 0) begin
      m_ena = '0;
      if (writable(p_addr[w])) m_ena[p_addr[w]] = 1'b1;
      m_d = p_data[w];
      // Winner moves to the back of the priority list.
      while (m_order[NREQ-1] != w) begin
        int t = m_order[0];
        for (int j = 0; j < NREQ - 1; j++) m_order[j] = m_order[j+1];
        m_order[NREQ-1] = t;
      end
      p_vld[w] = 0;
    end else begin
      m_ena = '0;
    end
    last_gnt = eg;
    @(posedge clk);
    #1;
    drive();
  endtask

  logic [NREQ-1:0]  seq_g [5];
  logic [NREGS-1:0] seq_e [5];

  initial begin
    seq_g = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    seq_e = '{32'h2, 32'h4, 32'h8, 32'h2, 32'h4};
    clear_go = 0;
    clrn = 0;
    for (int i = 0; i < NREQ; i++) begin
      p_vld[i] = 1; p_addr[i] = AW'(i + 1); p_data[i] = DW'(32'h100 + i);
    end
    drive();
    model_reset();

    // Reset held with all requests up.
    repeat (2) @(negedge clk);
    check("rst_gnt",  64'(gnt),        64'(0));
    check("rst_ena",  64'(reg_ena),    64'(0));
    check("rst_clr",  64'(reg_clr),    64'(0));
    check("rst_d",    64'(reg_d),      64'(0));
    check("rst_busy", 64'(clear_busy), 64'(0));
    @(posedge clk); #1;
    clrn = 1;
    tick();
    check("first_gnt", 64'(obs_gnt), 64'(3'b001));
    p_vld[0] = 1; drive();

    // Rotation with re-requests, then the backlog drains.
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rot_gnt", 64'(obs_gnt), 64'(seq_g[k]));
      check("rot_ena", 64'(obs_ena), 64'(seq_e[k]));
      if (k < 2) begin
        for (int i = 0; i < NREQ; i++) if (last_gnt[i]) p_vld[i] = 1;
        drive();
      end
    end

    // Single write path.
    p_vld[1] = 1; p_addr[1] = 5'd7; p_data[1] = 32'hDEAD_BEEF; drive();
    tick();
    check("wr_gnt", 64'(obs_gnt), 64'(3'b010));
    tick();
    check("wr_ena", 64'(obs_ena), 64'(32'h80));
    check("wr_d",   64'(obs_d),   64'(32'hDEAD_BEEF));

    // Clear sweep beats a simultaneous request.
    p_vld[1] = 1; p_addr[1] = 5'd3; p_data[1] = 32'h33; clear_go = 1; drive();
    tick();
    check("clr_go_gnt", 64'(obs_gnt), 64'(0));
    clear_go = 0; drive();
    for (int k = 0; k < NREGS; k++) begin
      tick();
      check("sweep_busy", 64'(obs_busy), 64'(1));
      check("sweep_clr",  64'(obs_clr),  64'(32'h1 << k));
    end
    tick();
    check("post_sweep_gnt",  64'(obs_gnt),  64'(3'b010));
    check("post_sweep_busy", 64'(obs_busy), 64'(0));
    tick();

    // Abort a sweep with reset at sweep cycle 10.
    clear_go = 1; drive();
    tick();
    clear_go = 0; drive();
    repeat (10) tick();
    clrn = 0;
    #1;
    check("abort_gnt",  64'(gnt),        64'(0));
    check("abort_ena",  64'(reg_ena),    64'(0));
    check("abort_clr",  64'(reg_clr),    64'(0));
    check("abort_d",    64'(reg_d),      64'(0));
    check("abort_busy", 64'(clear_busy), 64'(0));
    model_reset();
    for (int i = 0; i < NREQ; i++) p_vld[i] = 0;
    drive();
    @(posedge clk); #1;
    clrn = 1;
    tick();
    check("abort_idle_busy", 64'(obs_busy), 64'(0));
    check("abort_idle_clr",  64'(obs_clr),  64'(0));

    // Write to r0.
    p_vld[2] = 1; p_addr[2] = 5'd0; p_data[2] = 32'd5; drive();
    tick();
    check("r0_gnt", 64'(obs_gnt), 64'(3'b100));
    tick();
`ifdef REGWR_R0_PROTECT_EN
    check("r0_ena", 64'(obs_ena), 64'(0));
`else
    check("r0_ena", 64'(obs_ena), 64'(1));
    check("r0_d",   64'(obs_d),   64'(5));
`endif

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (!p_vld[i] && ($urandom % 2 == 0)) begin
          p_vld[i] = 1;
          p_addr[i] = AW'($urandom_range(0, NREGS - 1));
          p_data[i] = $urandom;
        end
      clear_go = ($urandom % 60 == 0);
      drive();
      tick();
    end
    clear_go = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
